// File: rtl/branch_unit.sv
// Execute-stage branch resolution with a 2-bit bimodal predictor table
// and saturating branch / mispredict performance counters.
package branch_pkg;
   typedef enum logic [2:0] {
      CMP_BEQ  = 3'b000,
      CMP_BNE  = 3'b001,
      CMP_BLT  = 3'b100,
      CMP_BGE  = 3'b101,
      CMP_BLTU = 3'b110,
      CMP_BGEU = 3'b111
   } cmp_op_t;
endpackage

module branch_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BHT_DEPTH = 64,
   parameter logic [1:0]  CTR_INIT  = 2'b01
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pred_pc_i,
   output logic            pred_taken_o,
   input  logic            res_valid_i,
   input  logic            res_is_branch_i,
   input  cmp_op_t         cmp_op_c_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic [XLEN-1:0] res_pc_i,
   input  logic [XLEN-1:0] res_imm_i,
   input  logic            res_pred_taken_i,
   output logic            branch_taken_o,
   output logic            mispredict_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [31:0]     br_count_o,
   output logic [31:0]     mispred_count_o
);

   localparam int unsigned IW = $clog2(BHT_DEPTH);

   logic [1:0]      bht [BHT_DEPTH];
   logic [IW-1:0]   pidx;
   logic [IW-1:0]   ridx;
   logic            lt_s;
   logic            lt_u;
   logic            eq;
   logic            cond;
   logic            br_event;
   logic [1:0]      ctr;
   logic [1:0]      ctr_nxt;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fall;
   logic [31:0]     br_cnt;
   logic [31:0]     mis_cnt;

   assign pidx = pred_pc_i[IW+1:2];
   assign ridx = res_pc_i[IW+1:2];

   // Read port has no bypass from the update port.
   assign pred_taken_o = bht[pidx][1];

   assign eq   = data1_i == data2_i;
   assign lt_s = $signed(data1_i) < $signed(data2_i);
   assign lt_u = data1_i < data2_i;

   always_comb begin
      cond = 1'b0;
      case (cmp_op_c_i)
         CMP_BEQ:  cond = eq;
         CMP_BNE:  cond = !eq;
         CMP_BLT:  cond = lt_s;
         CMP_BGE:  cond = !lt_s;
         CMP_BLTU: cond = lt_u;
         CMP_BGEU: cond = !lt_u;
         default:  cond = 1'b0;
      endcase
   end

   assign branch_taken_o = res_is_branch_i & cond;

   assign target        = res_pc_i + res_imm_i;
   assign fall          = res_pc_i + XLEN'(4);
   assign redirect_pc_o = branch_taken_o ? target : fall;

   assign br_event     = res_valid_i & res_is_branch_i;
   assign mispredict_o = br_event & (branch_taken_o != res_pred_taken_i);

   assign ctr = bht[ridx];

   always_comb begin
      ctr_nxt = ctr;
      if (branch_taken_o) begin
         if (ctr != 2'b11) ctr_nxt = ctr + 2'b01;
      end else begin
         if (ctr != 2'b00) ctr_nxt = ctr - 2'b01;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(BHT_DEPTH); i++) bht[i] <= CTR_INIT;
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else if (br_event) begin
         bht[ridx] <= ctr_nxt;
         if (br_cnt != '1) br_cnt <= br_cnt + 32'd1;
         if (mispredict_o && mis_cnt != '1) mis_cnt <= mis_cnt + 32'd1;
      end
   end

   assign br_count_o      = br_cnt;
   assign mispred_count_o = mis_cnt;

endmodule
